la_owner_arbiter: RTL and testbench
===================================

LA_OWNER_ARBITER -- requirements
Module: la_owner_arbiter

Interface
REQ-001 SHALL have parameter NUM_TEAMS, default 4, number of team designs sharing the LA (1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0100, Wishbone base of the 16-byte register window.
REQ-003 SHALL have ports, one clock; reset is synchronous and active-high:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  ack.
- wbs_dat_o  out  32  read data.
- team_req  in  NUM_TEAMS  bit i-1 = team i requests the LA.
- designs_la_data_out  in  34*NUM_TEAMS  team i at bits [34*i-1 : 34*(i-1)].
- designs_la_oenb  in  34*NUM_TEAMS  same packing, active-low enables.
- team_grant  out  NUM_TEAMS  one-hot current owner.
- la_data_out  out  34  muxed data.
- la_oenb  out  34  muxed active-low enables.

Function
REQ-004 SHALL decode registers at BASE_ADDR+{0x0 CTRL, 0x4 OWNER, 0x8 SLICE, 0xC STATUS}; match on wbs_adr_i[31:4]==BASE_ADDR[31:4].
REQ-005 CTRL: bit0 EN, bit1 MODE (0 = fixed owner, 1 = round-robin); OWNER[3:0] = team index, 0 = none; SLICE[15:0] = slice length in cycles, 0 treated as 1; STATUS (RO) [3:0] = granted index, bit4 = HANDOFF active.
REQ-006 Writes SHALL honour wbs_sel_i per byte; STATUS writes and unmapped writes are ignored; unmapped reads return 0.
REQ-007 wbs_ack_o SHALL pulse high one cycle after a matched stb&cyc, for exactly one cycle, never on consecutive cycles.
REQ-008 FSM states: IDLE, GRANT, HANDOFF; grant index register cur (0 = none); pointer last (last granted team).
REQ-009 IDLE: no grant; exit to GRANT next cycle when EN=1 and:
- MODE=0: OWNER is in 1..NUM_TEAMS (team_req is ignored).
- MODE=1: any team_req is set; pick the first requester searching cyclically from last+1.
REQ-010 GRANT, MODE=0: on an OWNER change, EN=0 or MODE change, go to HANDOFF.
REQ-011 GRANT, MODE=1: slice counter increments each cycle from 0.
- Granted team drops its request: go to HANDOFF immediately.
- Counter == SLICE-1 and another team requests: go to HANDOFF.
- Counter == SLICE-1 and no other requester: stay in GRANT, counter restarts at 0.
REQ-012 HANDOFF SHALL last exactly one cycle with cur=0, then go to IDLE for re-arbitration; this enforces at least one dead cycle between owners.
REQ-013 While cur=k≠0: la_data_out/la_oenb SHALL equal team k's slices combinationally, and team_grant = one-hot bit k-1.
- Otherwise la_data_out=0, la_oenb=all ones, team_grant=0.
REQ-014 Config writes SHALL take effect the cycle after ack; a write landing in the same cycle as a slice expiry uses the old values.

Reset
REQ-015 On wb_rst_i, at the next edge: CTRL=0, OWNER=0, SLICE=1, state=IDLE, cur=0, last=NUM_TEAMS, counter=0, wbs_ack_o=0, wbs_dat_o=0.
REQ-016 Reset mid-grant SHALL release the LA in the same cycle; the next cycle has la_oenb=all ones.

Structure
REQ-017 A shared package SHALL hold the register offsets, CTRL bit positions, FSM state encoding and the 34-bit LA width constant.
REQ-018 One sub-module, la_rr_picker, SHALL be used: combinational cyclic next-requester search from (req, last).

Verification
REQ-019 Reset -> la_oenb=34'h3FFFFFFFF, team_grant=0, SLICE reads 1, STATUS reads 0.
REQ-020 MODE=0, EN=1, OWNER=2 -> team_grant=4'b0010 two cycles after ack; la_data_out tracks team 2; rewrite OWNER=3 -> one HANDOFF cycle (STATUS bit4=1, oenb all ones), then team 3.
REQ-021 MODE=1, SLICE=4, team_req=4'b1111 -> grants rotate 1,2,3,4,1, each 4 cycles, with one dead cycle plus one IDLE cycle between owners.
REQ-022 MODE=1, only team 3 requests -> team 3 is held indefinitely across slice expiries with no HANDOFF.
REQ-023 Team 2 drops its request mid-slice -> HANDOFF next cycle; an unmapped read returns 0 with ack; a write with wbs_sel_i=4'b0001 to SLICE=32'h1234 yields SLICE=0x0034 from reset.
REQ-024 Assert wb_rst_i during a grant -> outputs match reset values one cycle later; assert ack never spans two cycles.

Source files
------------

// File: rtl/la_owner_arbiter_pkg.sv
// Shared constants for the logic-analyser owner arbiter: register map,
// CTRL bit positions, FSM encoding and LA bus width.
package la_owner_arbiter_pkg;

  localparam int LA_W  = 34;
  localparam int IDX_W = 4;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_OWNER  = 4'h4;
  localparam logic [3:0] OFF_SLICE  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_HANDOFF = 2'd2;

endpackage

// File: rtl/la_owner_arbiter_rr_picker.sv
// Cyclic next-requester search: returns the first requesting team after
// last_i (wrapping), as a 1-based index, or 0 when nobody requests.
module la_rr_picker
  import la_owner_arbiter_pkg::*;
#(
  parameter int NUM_TEAMS = 4
) (
  input  logic [NUM_TEAMS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic [IDX_W-1:0]     pick_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick_o = '0;
    idx    = 0;
    for (int off = NUM_TEAMS; off >= 1; off--) begin
      idx = int'(last_i) + off;
      if (idx > NUM_TEAMS) idx = idx - NUM_TEAMS;
      if (|(req_i & (NUM_TEAMS'(1) << (idx - 1)))) pick_o = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/la_owner_arbiter.sv
// Wishbone-configured arbiter that hands the shared logic analyser to one
// team design at a time, either a fixed owner or round-robin time slices.
module la_owner_arbiter
  import la_owner_arbiter_pkg::*;
#(
  parameter int          NUM_TEAMS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [NUM_TEAMS-1:0]      team_req,
  input  logic [LA_W*NUM_TEAMS-1:0] designs_la_data_out,
  input  logic [LA_W*NUM_TEAMS-1:0] designs_la_oenb,
  output logic [NUM_TEAMS-1:0]      team_grant,
  output logic [LA_W-1:0]           la_data_out,
  output logic [LA_W-1:0]           la_oenb
);

  logic        match, accept;
  logic        ack_q;
  logic [31:0] dat_q, rd_data;
  logic        wr_pend_q;
  logic [3:0]  wr_off_q;
  logic [1:0]  wr_sel_q;
  logic [15:0] wr_dat_q;
  logic [1:0]  ctrl_q;
  logic [3:0]  owner_q;
  logic [15:0] slice_q;
  logic        dat_unused;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cur_q, cur_d, last_q, last_d, pick;
  logic [15:0] cnt_q, cnt_d, slice_last;
  logic        gmode_q, gmode_d;
  logic        en, mode, owner_valid, cur_req, other_req, go_handoff;
  logic [NUM_TEAMS-1:0] cur_onehot;

  assign match      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept     = match & ~ack_q;
  assign dat_unused = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};
  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;

  always_comb begin
    case (wbs_adr_i[3:0])
      OFF_CTRL:   rd_data = {30'd0, ctrl_q};
      OFF_OWNER:  rd_data = {28'd0, owner_q};
      OFF_SLICE:  rd_data = {16'd0, slice_q};
      OFF_STATUS: rd_data = {27'd0, state_q == ST_HANDOFF, cur_q};
      default:    rd_data = '0;
    endcase
  end

  // Writes are captured with the ack and committed one edge later, so new
  // configuration becomes visible in the cycle after ack.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_off_q  <= '0;
      wr_sel_q  <= '0;
      wr_dat_q  <= '0;
      ctrl_q    <= '0;
      owner_q   <= '0;
      slice_q   <= 16'd1;
    end else begin
      ack_q     <= accept;
      dat_q     <= (accept & ~wbs_we_i) ? rd_data : '0;
      wr_pend_q <= accept & wbs_we_i;
      wr_off_q  <= wbs_adr_i[3:0];
      wr_sel_q  <= wbs_sel_i[1:0];
      wr_dat_q  <= wbs_dat_i[15:0];
      if (wr_pend_q) begin
        case (wr_off_q)
          OFF_CTRL:  if (wr_sel_q[0]) ctrl_q <= wr_dat_q[1:0];
          OFF_OWNER: if (wr_sel_q[0]) owner_q <= wr_dat_q[3:0];
          OFF_SLICE: begin
            if (wr_sel_q[0]) slice_q[7:0]  <= wr_dat_q[7:0];
            if (wr_sel_q[1]) slice_q[15:8] <= wr_dat_q[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  la_rr_picker #(.NUM_TEAMS(NUM_TEAMS)) u_picker (
    .req_i  (team_req),
    .last_i (last_q),
    .pick_o (pick)
  );

  assign en          = ctrl_q[CTRL_EN_BIT];
  assign mode        = ctrl_q[CTRL_MODE_BIT];
  assign owner_valid = (owner_q != 4'd0) && (owner_q <= 4'(NUM_TEAMS));
  assign slice_last  = (slice_q == 16'd0) ? 16'd0 : slice_q - 16'd1;

  always_comb begin
    for (int i = 0; i < NUM_TEAMS; i++) cur_onehot[i] = (cur_q == 4'(i + 1));
  end

  assign cur_req   = |(team_req & cur_onehot);
  assign other_req = |(team_req & ~cur_onehot);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gmode_d    = gmode_q;
    go_handoff = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cur_d = '0;
        cnt_d = '0;
        if (en && !mode && owner_valid) begin
          state_d = ST_GRANT;
          cur_d   = owner_q;
          last_d  = owner_q;
          gmode_d = 1'b0;
        end else if (en && mode && pick != 4'd0) begin
          state_d = ST_GRANT;
          cur_d   = pick;
          last_d  = pick;
          gmode_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!en || mode != gmode_q) go_handoff = 1'b1;
        else if (!mode) go_handoff = (owner_q != cur_q);
        else if (!cur_req) go_handoff = 1'b1;
        else if (cnt_q == slice_last) begin
          if (other_req) go_handoff = 1'b1;
          else cnt_d = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      ST_HANDOFF: begin
        state_d = ST_IDLE;
        cur_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cur_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (go_handoff) begin
      state_d = ST_HANDOFF;
      cur_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= 4'(NUM_TEAMS);
      cnt_q   <= '0;
      gmode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gmode_q <= gmode_d;
    end
  end

  // Reset gates the mux directly so the LA is released in the reset cycle.
  always_comb begin
    la_data_out = '0;
    la_oenb     = '1;
    team_grant  = '0;
    if (!wb_rst_i) begin
      team_grant = cur_onehot;
      for (int i = 0; i < NUM_TEAMS; i++) begin
        if (cur_onehot[i]) begin
          la_data_out = designs_la_data_out[i*LA_W +: LA_W];
          la_oenb     = designs_la_oenb[i*LA_W +: LA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_la_owner_arbiter.sv
// Self-checking bench for la_owner_arbiter: register vectors, fixed-owner
// handoffs, round-robin rotation, hold, drop and reset-during-grant.
module tb_la_owner_arbiter;
  import la_owner_arbiter_pkg::*;

  localparam int          NT   = 4;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic                 wb_clk_i, wb_rst_i;
  logic                 wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_adr_i, wbs_dat_i;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NT-1:0]        team_req, team_grant;
  logic [LA_W*NT-1:0]   designs_la_data_out, designs_la_oenb;
  logic [LA_W-1:0]      la_data_out, la_oenb;

  logic [LA_W-1:0] team_data [NT];
  logic [LA_W-1:0] team_oenb [NT];

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_viol     = 0;
  logic ack_prev   = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;
  exp_t sb_q[$];
  logic [NT-1:0] grant_q[$];

  typedef struct {
    logic [3:0]  off;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [3:0]  rd_off;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [3:0] owner;
    int         exp_idx;
  } own_vec_t;

  reg_vec_t reg_tbl [10];
  own_vec_t own_tbl [5];

  la_owner_arbiter #(.NUM_TEAMS(NT), .BASE_ADDR(BASE)) dut (
    .wb_clk_i            (wb_clk_i),
    .wb_rst_i            (wb_rst_i),
    .wbs_stb_i           (wbs_stb_i),
    .wbs_cyc_i           (wbs_cyc_i),
    .wbs_we_i            (wbs_we_i),
    .wbs_sel_i           (wbs_sel_i),
    .wbs_adr_i           (wbs_adr_i),
    .wbs_dat_i           (wbs_dat_i),
    .wbs_ack_o           (wbs_ack_o),
    .wbs_dat_o           (wbs_dat_o),
    .team_req            (team_req),
    .designs_la_data_out (designs_la_data_out),
    .designs_la_oenb     (designs_la_oenb),
    .team_grant          (team_grant),
    .la_data_out         (la_data_out),
    .la_oenb             (la_oenb)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      designs_la_data_out[i*LA_W +: LA_W] = team_data[i];
      designs_la_oenb[i*LA_W +: LA_W]     = team_oenb[i];
    end
  end

  always @(negedge wb_clk_i) begin
    if (wbs_ack_o && ack_prev) ack_viol <= ack_viol + 1;
    ack_prev <= wbs_ack_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NT-1:0] model_grant(int idx);
    return (idx == 0) ? '0 : NT'(1) << (idx - 1);
  endfunction

  function automatic logic [LA_W-1:0] model_data(int idx);
    return (idx == 0) ? '0 : team_data[idx-1];
  endfunction

  function automatic logic [LA_W-1:0] model_oenb(int idx);
    return (idx == 0) ? '1 : team_oenb[idx-1];
  endfunction

  task automatic randomize_teams();
    for (int i = 0; i < NT; i++) begin
      team_data[i] = LA_W'({$urandom(), $urandom()});
      team_oenb[i] = LA_W'({$urandom(), $urandom()});
    end
  endtask

  task automatic check_la(input string name, input int idx);
    check({name, "_grant"}, 64'(team_grant), 64'(model_grant(idx)));
    check({name, "_data"}, 64'(la_data_out), 64'(model_data(idx)));
    check({name, "_oenb"}, 64'(la_oenb), 64'(model_oenb(idx)));
  endtask

  // Drives a transfer from the current time and waits (bounded) for ack.
  task automatic wb_xfer(input logic we, input logic [3:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, output logic acked, output logic [31:0] rdat);
    acked     = 1'b0;
    rdat      = '0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = BASE + 32'(off);
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i);
      #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic acked;
    logic [31:0] rdat;
    wb_xfer(1'b1, off, dat, sel, acked, rdat);
    if (!acked) check("write_ack_timeout", 64'(acked), 64'd1);
  endtask

  task automatic wb_read(input logic [3:0] off, input string name, input logic [31:0] exp);
    logic acked;
    logic [31:0] rdat;
    exp_t e;
    sb_q.push_back('{name: name, value: exp});
    wb_xfer(1'b0, off, 32'd0, 4'hF, acked, rdat);
    e = sb_q.pop_front();
    if (!acked) check({e.name, "_ack_timeout"}, 64'(acked), 64'd1);
    else check(e.name, 64'(rdat), 64'(e.value));
  endtask

  initial begin
    int hold;
    int seq [5];

    reg_tbl[0] = '{OFF_SLICE,  32'h0000_1234, 4'b0001, OFF_SLICE,  32'h0000_0034};
    reg_tbl[1] = '{OFF_SLICE,  32'hABCD_5678, 4'b0011, OFF_SLICE,  32'h0000_5678};
    reg_tbl[2] = '{OFF_SLICE,  32'h0000_9900, 4'b0010, OFF_SLICE,  32'h0000_9978};
    reg_tbl[3] = '{OFF_OWNER,  32'hFFFF_FFF5, 4'b1111, OFF_OWNER,  32'h0000_0005};
    reg_tbl[4] = '{OFF_OWNER,  32'h0000_0003, 4'b0000, OFF_OWNER,  32'h0000_0005};
    reg_tbl[5] = '{OFF_CTRL,   32'hFFFF_FFFC, 4'b1111, OFF_CTRL,   32'h0000_0000};
    reg_tbl[6] = '{OFF_STATUS, 32'hFFFF_FFFF, 4'b1111, OFF_STATUS, 32'h0000_0000};
    reg_tbl[7] = '{4'h1,       32'hFFFF_FFFF, 4'b1111, 4'h1,       32'h0000_0000};
    reg_tbl[8] = '{4'h2,       32'h0000_0007, 4'b1111, OFF_OWNER,  32'h0000_0005};
    reg_tbl[9] = '{OFF_SLICE,  32'h0000_0000, 4'b1111, OFF_SLICE,  32'h0000_0000};

    own_tbl[0] = '{4'd1, 1};
    own_tbl[1] = '{4'd4, 4};
    own_tbl[2] = '{4'd0, 0};
    own_tbl[3] = '{4'd5, 0};
    own_tbl[4] = '{4'd2, 2};

    seq = '{1, 2, 3, 4, 1};

    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = '0;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    team_req  = '0;
    randomize_teams();
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    check_la("reset", 0);
    check("reset_ack", 64'(wbs_ack_o), 64'd0);
    check("reset_dat", 64'(wbs_dat_o), 64'd0);
    wb_read(OFF_SLICE, "reset_slice", 32'd1);
    wb_read(OFF_STATUS, "reset_status", 32'd0);
    wb_read(OFF_CTRL, "reset_ctrl", 32'd0);

    for (int i = 0; i < 10; i++) begin
      wb_write(reg_tbl[i].off, reg_tbl[i].wdat, reg_tbl[i].sel);
      wb_read(reg_tbl[i].rd_off, $sformatf("reg_vec%0d", i), reg_tbl[i].exp);
    end

    // Fixed owner: grant appears two cycles after the CTRL ack.
    wb_write(OFF_OWNER, 32'd2, 4'hF);
    wb_write(OFF_CTRL, 32'd1, 4'hF);
    @(negedge wb_clk_i);
    check("fixed_ack_cycle_grant", 64'(team_grant), 64'd0);
    @(negedge wb_clk_i);
    check("fixed_ack_plus1_grant", 64'(team_grant), 64'd0);
    @(negedge wb_clk_i);
    check_la("fixed_owner2", 2);
    randomize_teams();
    #1;
    check_la("fixed_owner2_track", 2);

    wb_write(OFF_OWNER, 32'd3, 4'hF);
    @(negedge wb_clk_i);
    check("rewrite_ack_cycle_grant", 64'(team_grant), 64'(model_grant(2)));
    @(negedge wb_clk_i);
    check("rewrite_plus1_grant", 64'(team_grant), 64'(model_grant(2)));
    @(negedge wb_clk_i);
    check_la("handoff", 0);
    wb_read(OFF_STATUS, "handoff_status", 32'h10);
    @(negedge wb_clk_i);
    check("idle_after_handoff_grant", 64'(team_grant), 64'd0);
    @(negedge wb_clk_i);
    check_la("fixed_owner3", 3);

    for (int i = 0; i < 5; i++) begin
      wb_write(OFF_OWNER, 32'(own_tbl[i].owner), 4'hF);
      repeat (6) @(negedge wb_clk_i);
      randomize_teams();
      #1;
      check_la($sformatf("own_vec%0d", i), own_tbl[i].exp_idx);
      wb_read(OFF_STATUS, $sformatf("own_vec%0d_status", i), 32'(own_tbl[i].exp_idx));
    end

    // Reset while team 2 holds the LA.
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_la("rst_mid_grant", 0);
    check("rst_mid_grant_ack", 64'(wbs_ack_o), 64'd0);
    check("rst_mid_grant_dat", 64'(wbs_dat_o), 64'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_la("post_rst", 0);
    wb_read(OFF_SLICE, "post_rst_slice", 32'd1);
    wb_read(OFF_STATUS, "post_rst_status", 32'd0);

    // Round robin, all four teams requesting, SLICE=4.
    team_req = 4'b1111;
    wb_write(OFF_SLICE, 32'd4, 4'hF);
    wb_write(OFF_CTRL, 32'd3, 4'hF);
    grant_q.push_back('0);
    grant_q.push_back('0);
    for (int k = 0; k < 5; k++) begin
      repeat (4) grant_q.push_back(model_grant(seq[k]));
      repeat (2) grant_q.push_back('0);
    end
    for (int c = 0; grant_q.size() > 0; c++) begin
      @(negedge wb_clk_i);
      check($sformatf("rr_cycle%0d", c), 64'(team_grant), 64'(grant_q.pop_front()));
    end

    // Only team 3 requests: held across slice expiries.
    team_req = 4'b0100;
    repeat (8) @(negedge wb_clk_i);
    hold = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wb_clk_i);
      if (team_grant == 4'b0100) hold++;
    end
    check("rr_hold_team3_cycles", 64'(hold), 64'd20);

    // Team 2 drops its request mid-slice.
    wb_write(OFF_SLICE, 32'd100, 4'hF);
    team_req = 4'b0010;
    repeat (6) @(negedge wb_clk_i);
    check("drop_setup_grant", 64'(team_grant), 64'(model_grant(2)));
    team_req = 4'b1010;
    repeat (3) @(negedge wb_clk_i);
    check("drop_midslice_grant", 64'(team_grant), 64'(model_grant(2)));
    team_req = 4'b1000;
    #1;
    check("drop_same_cycle_grant", 64'(team_grant), 64'(model_grant(2)));
    @(negedge wb_clk_i);
    check_la("drop_handoff", 0);
    @(negedge wb_clk_i);
    check("drop_idle_grant", 64'(team_grant), 64'd0);
    @(negedge wb_clk_i);
    check_la("drop_next_owner4", 4);

    @(negedge wb_clk_i);
    check("ack_never_consecutive", 64'(ack_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
